// File: rtl/intc_pkg.sv
// rtl/intc_pkg.sv - shared constants for the interrupt controller
package intc_pkg;
    localparam int NUM_IRQ = 4;

    localparam logic [1:0] OFF_MASK    = 2'd0;
    localparam logic [1:0] OFF_PENDING = 2'd1;
    localparam logic [1:0] OFF_EDGE    = 2'd2;
    localparam logic [1:0] OFF_ACTIVE  = 2'd3;

    localparam logic [7:0] IO_PAGE = 8'h10;
endpackage

// File: rtl/irq_sync.sv
// rtl/irq_sync.sv - one request line: two-flop synchroniser plus rising-edge detect
// Optional feature macro: INTC_EDGE_EN (adds the delayed copy used for edge detection)
module irq_sync (
    input  logic clk,
    input  logic reset,
    input  logic src,
    output logic s,
    output logic rise
);
    logic meta;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta <= 1'b0;
            s    <= 1'b0;
        end else begin
            meta <= src;
            s    <= meta;
        end
    end

`ifdef INTC_EDGE_EN
    logic s_d;

    // s_d follows s regardless of trigger mode, so switching to edge mode
    // while the line is already high does not look like a new rise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s_d <= 1'b0;
        end else begin
            s_d <= s;
        end
    end

    assign rise = s & ~s_d;
`else
    assign rise = 1'b0;
`endif
endmodule

// File: rtl/interrupt_controller.sv
// rtl/interrupt_controller.sv - 4-line maskable interrupt controller on the 0x10xx I/O page
// Optional feature macro: INTC_EDGE_EN (per-line edge trigger and EDGE register)
module interrupt_controller
    import intc_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR = 8'hF0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_IRQ-1:0]  irq_src,
    input  logic [15:0]         address,
    input  logic [7:0]          din,
    input  logic                write_en,
    input  logic                read_en,
    output logic [7:0]          dout,
    output logic                interrupt_0,
    output logic                interrupt_1,
    output logic                interrupt_2,
    output logic                interrupt_3,
    input  logic                interrupt_0_clr,
    input  logic                interrupt_1_clr,
    input  logic                interrupt_2_clr,
    input  logic                interrupt_3_clr
);
    logic [NUM_IRQ-1:0] s;
    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] mask_q;
    logic [NUM_IRQ-1:0] pend_q;
    logic [NUM_IRQ-1:0] pend_d;
    logic [NUM_IRQ-1:0] edge_q;
    logic [NUM_IRQ-1:0] clr;
    logic [7:0]         rdata;
    logic               hit;
    logic               wr;
    logic               rd;
    logic [1:0]         offset;
    logic               unused_din;

    assign unused_din = ^din[7:NUM_IRQ];

    for (genvar n = 0; n < NUM_IRQ; n++) begin : g_sync
        irq_sync u_sync (
            .clk  (clk),
            .reset(reset),
            .src  (irq_src[n]),
            .s    (s[n]),
            .rise (rise[n])
        );
    end

    assign hit    = (address[15:8] == IO_PAGE) && (address[7:2] == BASE_ADDR[7:2]);
    assign offset = address[1:0];
    assign wr     = write_en && hit;
    assign rd     = read_en && hit;

    assign clr = {interrupt_3_clr, interrupt_2_clr, interrupt_1_clr, interrupt_0_clr}
               | ({NUM_IRQ{wr && (offset == OFF_PENDING)}} & din[NUM_IRQ-1:0]);

`ifdef INTC_EDGE_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            edge_q <= '0;
        end else if (wr && (offset == OFF_EDGE)) begin
            edge_q <= din[NUM_IRQ-1:0];
        end
    end

    // Edge lines: a rise beats a same-cycle clear. Level lines: the clear
    // takes this cycle and a still-high source re-sets on the next one.
    assign pend_d = (edge_q & (rise | (pend_q & ~clr)))
                  | (~edge_q & ~clr & (s | pend_q));
`else
    logic unused_rise;

    assign unused_rise = ^rise;
    assign edge_q      = '0;
    assign pend_d      = ~clr & (s | pend_q);
`endif

    always_comb begin
        rdata = 8'h00;
        case (offset)
            OFF_MASK:    rdata = {{(8-NUM_IRQ){1'b0}}, mask_q};
            OFF_PENDING: rdata = {{(8-NUM_IRQ){1'b0}}, pend_q};
            OFF_EDGE:    rdata = {{(8-NUM_IRQ){1'b0}}, edge_q};
            OFF_ACTIVE:  rdata = {{(8-NUM_IRQ){1'b0}}, pend_q & mask_q};
            default:     rdata = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mask_q <= '0;
            pend_q <= '0;
            dout   <= 8'h00;
        end else begin
            if (wr && (offset == OFF_MASK)) begin
                mask_q <= din[NUM_IRQ-1:0];
            end
            pend_q <= pend_d;
            // Zero when not selected so several blocks can be OR-ed onto one read bus.
            dout   <= rd ? rdata : 8'h00;
        end
    end

    assign interrupt_0 = pend_q[0] & mask_q[0];
    assign interrupt_1 = pend_q[1] & mask_q[1];
    assign interrupt_2 = pend_q[2] & mask_q[2];
    assign interrupt_3 = pend_q[3] & mask_q[3];
endmodule

// File: tb/tb_interrupt_controller.sv
// tb/tb_interrupt_controller.sv - directed self-checking bench for interrupt_controller
module tb_interrupt_controller;
    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  irq_src;
    logic [15:0] address;
    logic [7:0]  din;
    logic        write_en;
    logic        read_en;
    logic [7:0]  dout;
    logic        interrupt_0, interrupt_1, interrupt_2, interrupt_3;
    logic        interrupt_0_clr, interrupt_1_clr, interrupt_2_clr, interrupt_3_clr;
    logic [7:0]  rd;
    int          n_cmp = 0;
    int          n_err = 0;

    interrupt_controller #(.BASE_ADDR(8'hF0)) dut (
        .clk            (clk),
        .reset          (reset),
        .irq_src        (irq_src),
        .address        (address),
        .din            (din),
        .write_en       (write_en),
        .read_en        (read_en),
        .dout           (dout),
        .interrupt_0    (interrupt_0),
        .interrupt_1    (interrupt_1),
        .interrupt_2    (interrupt_2),
        .interrupt_3    (interrupt_3),
        .interrupt_0_clr(interrupt_0_clr),
        .interrupt_1_clr(interrupt_1_clr),
        .interrupt_2_clr(interrupt_2_clr),
        .interrupt_3_clr(interrupt_3_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [7:0] lo, input logic [7:0] data);
        address  = {8'h10, lo};
        din      = data;
        write_en = 1'b1;
        step();
        write_en = 1'b0;
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [7:0] data);
        address = a;
        read_en = 1'b1;
        step();
        read_en = 1'b0;
        data    = dout;
    endtask

    function automatic logic [7:0] ints();
        return {4'h0, interrupt_3, interrupt_2, interrupt_1, interrupt_0};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; irq_src = 4'hF; address = 16'h0000; din = 8'h00;
        write_en = 1'b0; read_en = 1'b0;
        interrupt_0_clr = 1'b0; interrupt_1_clr = 1'b0;
        interrupt_2_clr = 1'b0; interrupt_3_clr = 1'b0;

        // Reset held with all sources high
        step(3);
        check("reset_ints", ints(), 8'h00);
        check("reset_dout", dout, 8'h00);
        reset = 1'b1;
        step(3);
        bus_read(16'h10F1, rd);
        check("pend_after_reset", rd, 8'h0F);
        check("masked_ints", ints(), 8'h00);
        irq_src = 4'h0;
        step(3);
        bus_write(8'hF1, 8'h0F);
        bus_read(16'h10F1, rd);
        check("pend_w1c_all", rd, 8'h00);

        // Level path on line 0
        bus_write(8'hF0, 8'h01);
        irq_src = 4'h1;
        step(2);
        check("lvl_edge2", ints(), 8'h00);
        step();
        check("lvl_edge3", ints(), 8'h01);
        interrupt_0_clr = 1'b1;
        step();
        interrupt_0_clr = 1'b0;
        check("lvl_clr_low", ints(), 8'h00);
        step();
        check("lvl_reset_high", ints(), 8'h01);
        irq_src = 4'h0;
        step(2);
        interrupt_0_clr = 1'b1;
        step();
        interrupt_0_clr = 1'b0;
        check("lvl_clr_src_low", ints(), 8'h00);
        step(2);
        check("lvl_stays_low", ints(), 8'h00);

`ifdef INTC_EDGE_EN
        // Edge path on line 1
        bus_write(8'hF2, 8'h02);
        bus_read(16'h10F2, rd);
        check("edge_reg", rd, 8'h02);
        bus_write(8'hF0, 8'h02);
        irq_src = 4'h2;
        step(3);
        check("edge_set", ints(), 8'h02);
        step(3);
        check("edge_hold", ints(), 8'h02);
        bus_write(8'hF1, 8'h02);
        check("edge_w1c", ints(), 8'h00);
        step(3);
        check("edge_no_reset_high_src", ints(), 8'h00);
        irq_src = 4'h0;
        step(3);
        irq_src = 4'h2;
        step(3);
        check("edge_second_rise", ints(), 8'h02);
        bus_write(8'hF1, 8'h02);

        // Rise on line 2 lands on the same edge as interrupt_2_clr
        bus_write(8'hF2, 8'h06);
        bus_write(8'hF0, 8'h04);
        irq_src = 4'h6;
        step(2);
        interrupt_2_clr = 1'b1;
        step();
        interrupt_2_clr = 1'b0;
        check("collision_int2", ints(), 8'h04);
        bus_read(16'h10F1, rd);
        check("collision_pend", rd, 8'h04);
        bus_write(8'hF2, 8'h00);
`else
        bus_write(8'hF2, 8'h06);
        bus_read(16'h10F2, rd);
        check("edge_reg_absent", rd, 8'h00);
`endif

        // Bus behaviour with PENDING = 5, MASK = 4
        irq_src = 4'h0;
        step(3);
        bus_write(8'hF1, 8'h0F);
        irq_src = 4'h5;
        step(3);
        irq_src = 4'h0;
        step(3);
        bus_write(8'hF0, 8'h04);
        check("bus_ints", ints(), 8'h04);
        bus_read(16'h10F3, rd);
        check("read_active", rd, 8'h04);
        step();
        check("dout_idle_zero", dout, 8'h00);
        bus_read(16'h10F1, rd);
        check("read_pending", rd, 8'h05);
        bus_read(16'h10F4, rd);
        check("read_miss", rd, 8'h00);
        bus_write(8'hF3, 8'hFF);
        bus_read(16'h10F0, rd);
        check("active_wr_mask", rd, 8'h04);
        bus_read(16'h10F1, rd);
        check("active_wr_pend", rd, 8'h05);
        address  = 16'h10F0;
        din      = 8'h01;
        read_en  = 1'b1;
        write_en = 1'b1;
        step();
        read_en  = 1'b0;
        write_en = 1'b0;
        check("rw_pre_write", dout, 8'h04);
        bus_read(16'h10F0, rd);
        check("rw_post_write", rd, 8'h01);

        // Asynchronous reset with interrupt_3 active
        bus_write(8'hF0, 8'h08);
        irq_src = 4'h8;
        step(3);
        check("int3_active", ints(), 8'h08);
        #2 reset = 1'b0;
        #1;
        check("async_drop", ints(), 8'h00);
        irq_src = 4'h0;
        @(negedge clk);
        reset = 1'b1;
        step();
        bus_read(16'h10F0, rd);
        check("post_rst_mask", rd, 8'h00);
        bus_read(16'h10F1, rd);
        check("post_rst_pend", rd, 8'h00);
        bus_read(16'h10F2, rd);
        check("post_rst_edge", rd, 8'h00);
        bus_read(16'h10F3, rd);
        check("post_rst_active", rd, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
